serial_frame_rx: RTL
====================

# serial_frame_rx

Serial frame receiver that consumes the bit stream leaving the SISO shift register stage and rebuilds parallel words. It detects a start bit, shifts in DATA_W data bits LSB first, checks even parity and the stop bit, and presents the word on a valid/ready output through a one-entry holding register. Malformed frames and overruns are flagged with single-cycle pulses, and a wrapping counter tracks delivered frames.

## Interface
- DATA_W, 8, data bits per frame (≥1)
- CNT_W, 8, width of delivered-frame counter
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- serial_in  input  1  serial line (delayed SISO output), idle level 0
- out_ready  input  1  downstream accepts out_data when high with out_valid
- out_data  output  DATA_W  received word
- out_perr  output  1  parity error flag travelling with out_data
- out_valid  output  1  out_data/out_perr valid
- err_frame  output  1  one-cycle pulse: stop bit was 1, frame dropped
- err_overrun  output  1  one-cycle pulse: frame completed while holding register full, frame dropped
- frame_cnt  output  CNT_W  count of frames loaded into holding register, wraps
- busy  output  1  high in any state other than IDLE

## Operation
- Frame on serial_in, one bit per clock: start (1), DATA_W data bits LSB first, parity, stop (0).
- Even parity: XOR of data bits and parity bit must be 0; otherwise out_perr=1 and the word is still delivered.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: serial_in=1 → DATA, bit index cleared; serial_in=0 → stay.
  - DATA: shift bit into shift register at position index; after bit DATA_W-1 → PARITY.
  - PARITY: capture parity bit → STOP.
  - STOP: serial_in=0 → attempt load; serial_in=1 → pulse err_frame, discard. Always → IDLE.
- Load: if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, holding register takes shift data and parity result, out_valid=1, frame_cnt+1 (mod 2^CNT_W). Otherwise pulse err_overrun, holding register unchanged, frame_cnt unchanged.
- Handshake: out_valid stays high, out_data/out_perr stable, until a cycle with out_ready=1; then out_valid clears on that edge unless a load occurs on the same edge. out_ready with out_valid=0 ignored.
- Framing error takes priority: a frame with bad stop bit never produces err_overrun.
- Reset (rst=0, any time, including mid-frame): state IDLE, shift register and index 0, out_data 0, out_perr 0, out_valid 0, err_frame 0, err_overrun 0, frame_cnt 0, busy 0. Partial frame discarded; on release, receiver waits for a fresh start bit.

## Timing
- Start bit sampled at edge k (IDLE). Data bits at edges k+1..k+DATA_W, parity at k+DATA_W+1, stop at k+DATA_W+2.
- out_valid, out_data, out_perr, frame_cnt update at edge k+DATA_W+2; latency start-bit edge to out_valid = DATA_W+2 cycles.
- err_frame / err_overrun are registered, high for exactly the cycle after edge k+DATA_W+2.
- FSM is back in IDLE after edge k+DATA_W+2; earliest next start bit sampled at edge k+DATA_W+3 (frame period DATA_W+3 cycles).
- busy high from after edge k through edge k+DATA_W+2.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset then frame for 0xA5 (serial_in 1,1,0,1,0,0,1,0,1,0,0) with out_ready=1 → out_valid one cycle at edge k+10, out_data=0xA5, out_perr=0, frame_cnt=1.
- Frame for 0x3C with parity bit 1 → out_data=0x3C, out_perr=1, no error pulses.
- Frame for 0xFF with stop bit 1 → err_frame one cycle, out_valid stays 0, frame_cnt unchanged.
- out_ready=0; frames 0x11 then 0x22 back-to-back → out_data=0x11 held, err_overrun pulse at second stop edge, frame_cnt=1; raise out_ready → 0x11 accepted, out_valid drops. Repeat with out_ready=1 exactly on second stop edge → 0x22 loaded, no err_overrun.
- Assert rst after data bit 4 of a frame, release, send 0x5A → only 0x5A delivered, frame_cnt=1, all outputs 0 during reset.
- 256 valid frames, out_ready=1 → frame_cnt wraps to 0; idle-low line between frames never triggers a frame.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives start/data/parity/stop frames from a serial line,
// rebuilds DATA_W-bit words and presents them through a one-entry holding
// register with a valid/ready handshake. Framing errors and overruns are
// reported as single-cycle pulses; delivered frames are counted modulo 2^CNT_W.
module serial_frame_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_valid,
  output logic              err_frame,
  output logic              err_overrun,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift;
  logic              par_bit;

  logic stop_good;
  logic stop_bad;
  logic can_accept;
  logic do_load;
  logic do_overrun;

  // Frame-end decisions: a bad stop bit suppresses any load/overrun outcome.
  always_comb begin
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    can_accept = !out_valid || out_ready;
    do_load    = 1'b0;
    do_overrun = 1'b0;
    if (state == ST_STOP) begin
      stop_good = !serial_in;
      stop_bad  = serial_in;
    end
    do_load    = stop_good && can_accept;
    do_overrun = stop_good && !can_accept;
  end

  // Frame sequencing: start bit, DATA_W data bits, parity, stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (serial_in) state <= ST_DATA;
        ST_DATA:   if (idx == LAST_IDX) state <= ST_PARITY;
        ST_PARITY: state <= ST_STOP;
        ST_STOP:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Data capture: bits land at their index position, LSB first; parity held aside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (serial_in) idx <= '0;
        end
        ST_DATA: begin
          shift[idx] <= serial_in;
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        ST_PARITY: begin
          par_bit <= serial_in;
        end
        default: ;
      endcase
    end
  end

  // Holding register and handshake: a load on the same edge as an accept
  // replaces the word instead of clearing out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_perr  <= 1'b0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else if (do_load) begin
      out_data  <= shift;
      out_perr  <= ^{shift, par_bit};
      out_valid <= 1'b1;
      frame_cnt <= frame_cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error pulses: registered, high for exactly one cycle after the stop edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= stop_bad;
      err_overrun <= do_overrun;
    end
  end

  // busy derives only from the state register, so it stays a registered output.
  always_comb begin
    busy = (state != ST_IDLE);
  end

endmodule
